// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory freezes,
// EX-stage exception redirect and stall-cycle counting. Optional IRQ: PIPE_HAZARD_CTRL_IRQ_EN.
module pipe_hazard_ctrl #(
   parameter logic [31:0] ILLOP_VEC = 32'h80000004,
   parameter logic [31:0] XADR_VEC  = 32'h80000008,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IDrs,
   input  logic [4:0]       IDrt,
   input  logic             IDUsesRt,
   input  logic             IDBranchTaken,
   input  logic [4:0]       EXrt,
   input  logic             EXMemRead,
   input  logic [31:0]      EXPC,
   input  logic             EXIllop,
   input  logic             EXXadr,
   input  logic             MemBusy,
   input  logic             PerfClr,
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
   input  logic             IRQ,
`endif
   output logic             PCWrite,
   output logic             PCSelExc,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXWrite,
   output logic             IDEXFlush,
   output logic             EXMEMWrite,
   output logic             ExcTake,
   output logic [31:0]      ExcVector,
   output logic [CNT_W-1:0] StallCnt
);

   localparam logic [31:0] IRQ_VEC = 32'h80000000;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FREEZE   = 2'd1,
      EXC_HOLD = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   load_use;
   logic   exc_take;
   logic   redirect;
   logic   expc_unused;

   // Only the kernel-mode bit of the EX PC matters here.
   assign expc_unused = ^EXPC[30:0];

   assign load_use = EXMemRead && (EXrt != 5'd0) &&
                     ((EXrt == IDrs) || (IDUsesRt && (EXrt == IDrt)));

   // User-mode faults are taken only from RUN with memory ready; otherwise they wait.
   assign exc_take = (state == RUN) && !MemBusy && (EXIllop || EXXadr) && !EXPC[31];

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
   logic irq_pend;
   logic irq_take;

   assign irq_take = (state == RUN) && !MemBusy && !(EXIllop || EXXadr) &&
                     !EXPC[31] && irq_pend;
   assign redirect = exc_take || irq_take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_pend <= 1'b0;
      end else begin
         irq_pend <= IRQ || (irq_pend && !irq_take);
      end
   end
`else
   assign redirect = exc_take;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and pipeline controls, highest-priority event first.
   always_comb begin
      state_nxt  = RUN;
      PCWrite    = 1'b1;
      PCSelExc   = 1'b0;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXWrite  = 1'b1;
      IDEXFlush  = 1'b0;
      EXMEMWrite = 1'b1;
      ExcTake    = 1'b0;
      ExcVector  = ILLOP_VEC;

      if (redirect) begin
         state_nxt = EXC_HOLD;
      end else if (MemBusy) begin
         state_nxt = FREEZE;
      end

      if (redirect) begin
         ExcTake   = 1'b1;
         PCSelExc  = 1'b1;
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
         if (exc_take) begin
            ExcVector = EXIllop ? ILLOP_VEC : XADR_VEC;
         end else begin
            ExcVector = IRQ_VEC;
         end
      end else if (MemBusy) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
      end else if (load_use) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IDEXFlush = 1'b1;
      end else if (IDBranchTaken) begin
         IFIDFlush = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         StallCnt <= '0;
      end else if (PerfClr) begin
         StallCnt <= '0;
      end else if (!PCWrite && !(&StallCnt)) begin
         StallCnt <= StallCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: rule-level model checked every cycle plus directed literals.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W   = 8;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] V_ILL   = 32'h80000004;
   localparam logic [31:0] V_XADR  = 32'h80000008;

   logic        clk, reset;
   logic [4:0]  IDrs, IDrt, EXrt;
   logic        IDUsesRt, IDBranchTaken, EXMemRead, EXIllop, EXXadr, MemBusy, PerfClr;
   logic [31:0] EXPC;
   logic        IRQ;
   logic        PCWrite, PCSelExc, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite, ExcTake;
   logic [31:0] ExcVector;
   logic [CNT_W-1:0] StallCnt;

   int n_cmp = 0;
   int n_err = 0;

   pipe_hazard_ctrl #(.ILLOP_VEC(V_ILL), .XADR_VEC(V_XADR), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .IDrs(IDrs), .IDrt(IDrt), .IDUsesRt(IDUsesRt),
      .IDBranchTaken(IDBranchTaken), .EXrt(EXrt), .EXMemRead(EXMemRead), .EXPC(EXPC),
      .EXIllop(EXIllop), .EXXadr(EXXadr), .MemBusy(MemBusy), .PerfClr(PerfClr),
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
      .IRQ(IRQ),
`endif
      .PCWrite(PCWrite), .PCSelExc(PCSelExc), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
      .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush), .EXMEMWrite(EXMEMWrite),
      .ExcTake(ExcTake), .ExcVector(ExcVector), .StallCnt(StallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        pcw, sel, ifidw, ifidf, idexw, idexf, exmw, take;
      logic [31:0] vec;
   } exp_t;

   // Model state: the controller may take a fault only if last cycle neither froze nor redirected.
   bit m_prev_busy, m_prev_redir, m_pend;
   int m_cnt;

   function automatic exp_t model_out();
      exp_t e;
      bit   may_take, fault, irq, lu;
      may_take = !m_prev_busy && !m_prev_redir && !MemBusy && !EXPC[31];
      fault    = may_take && (EXIllop || EXXadr);
      irq      = 1'b0;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
      irq      = may_take && !(EXIllop || EXXadr) && m_pend;
`endif
      lu = EXMemRead && EXrt != 0 && (EXrt == IDrs || (IDUsesRt && EXrt == IDrt));
      e  = '{pcw:1, sel:0, ifidw:1, ifidf:0, idexw:1, idexf:0, exmw:1, take:0, vec:V_ILL};
      if (fault || irq) begin
         e.take = 1; e.sel = 1; e.ifidf = 1; e.idexf = 1;
         e.vec  = irq ? 32'h80000000 : (EXIllop ? V_ILL : V_XADR);
      end else if (MemBusy) begin
         e.pcw = 0; e.ifidw = 0; e.idexw = 0; e.exmw = 0;
      end else if (lu) begin
         e.pcw = 0; e.ifidw = 0; e.idexf = 1;
      end else if (IDBranchTaken) begin
         e.ifidf = 1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      exp_t e;
      if (!reset) begin
         m_prev_busy  <= 1'b0;
         m_prev_redir <= 1'b0;
         m_pend       <= 1'b0;
         m_cnt        <= 0;
      end else begin
         e = model_out();
         m_prev_redir <= e.take;
         m_prev_busy  <= MemBusy && !e.take;
         m_pend       <= IRQ || (m_pend && !(e.take && e.vec == 32'h80000000));
         if (PerfClr)     m_cnt <= 0;
         else if (!e.pcw) m_cnt <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
   end

   // Every cycle out of reset, all outputs against the model.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         e = model_out();
         chk("m_PCWrite",    32'(PCWrite),    32'(e.pcw));
         chk("m_PCSelExc",   32'(PCSelExc),   32'(e.sel));
         chk("m_IFIDWrite",  32'(IFIDWrite),  32'(e.ifidw));
         chk("m_IFIDFlush",  32'(IFIDFlush),  32'(e.ifidf));
         chk("m_IDEXWrite",  32'(IDEXWrite),  32'(e.idexw));
         chk("m_IDEXFlush",  32'(IDEXFlush),  32'(e.idexf));
         chk("m_EXMEMWrite", 32'(EXMEMWrite), 32'(e.exmw));
         chk("m_ExcTake",    32'(ExcTake),    32'(e.take));
         chk("m_ExcVector",  ExcVector,       e.vec);
         chk("m_StallCnt",   32'(StallCnt),   32'(m_cnt));
      end
   end

   task automatic idle();
      IDrs = 0; IDrt = 0; EXrt = 0; IDUsesRt = 0; IDBranchTaken = 0; EXMemRead = 0;
      EXIllop = 0; EXXadr = 0; MemBusy = 0; PerfClr = 0; EXPC = 32'h00400000; IRQ = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_PCWrite", 32'(PCWrite), 32'd1);
      chk("rst_IFIDFlush", 32'(IFIDFlush), 32'd0);
      chk("rst_ExcVector", ExcVector, 32'h80000004);
      chk("rst_StallCnt", 32'(StallCnt), 32'd0);
      tick();

      // load-use on rs
      EXMemRead = 1; EXrt = 5; IDrs = 5;
      @(negedge clk);
      chk("lu_PCWrite", 32'(PCWrite), 32'd0);
      chk("lu_IFIDWrite", 32'(IFIDWrite), 32'd0);
      chk("lu_IDEXFlush", 32'(IDEXFlush), 32'd1);
      tick(); idle();
      @(negedge clk);
      chk("lu_StallCnt", 32'(StallCnt), 32'd1);
      tick();
      EXMemRead = 1; EXrt = 0; IDrs = 0;
      @(negedge clk);
      chk("lu_r0_PCWrite", 32'(PCWrite), 32'd1);
      tick();
      EXMemRead = 1; EXrt = 7; IDrt = 7; IDUsesRt = 1;
      @(negedge clk);
      chk("lu_rt_PCWrite", 32'(PCWrite), 32'd0);
      tick();
      IDUsesRt = 0;
      @(negedge clk);
      chk("lu_nort_PCWrite", 32'(PCWrite), 32'd1);
      tick(); idle();

      // illegal-op exception, then the hold cycle, then both faults together
      EXIllop = 1; EXPC = 32'h00400010;
      @(negedge clk);
      chk("ill_ExcTake", 32'(ExcTake), 32'd1);
      chk("ill_ExcVector", ExcVector, 32'h80000004);
      chk("ill_Flushes", {30'd0, IFIDFlush, IDEXFlush}, 32'd3);
      chk("ill_PCSelExc", 32'(PCSelExc), 32'd1);
      tick();
      @(negedge clk);
      chk("hold_ExcTake", 32'(ExcTake), 32'd0);
      tick();
      EXXadr = 1;
      @(negedge clk);
      chk("both_ExcVector", ExcVector, 32'h80000004);
      chk("both_ExcTake", 32'(ExcTake), 32'd1);
      tick(); idle(); tick();

      // address fault deferred behind a memory freeze (StallCnt is 2 here)
      EXXadr = 1; MemBusy = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("frz_ExcTake", 32'(ExcTake), 32'd0);
         chk("frz_Writes", {28'd0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite}, 32'd0);
         tick();
      end
      MemBusy = 0;
      @(negedge clk);
      chk("frz_StallCnt", 32'(StallCnt), 32'd5);
      chk("frz_exit_ExcTake", 32'(ExcTake), 32'd0);
      tick();
      @(negedge clk);
      chk("xadr_ExcTake", 32'(ExcTake), 32'd1);
      chk("xadr_ExcVector", ExcVector, 32'h80000008);
      tick(); idle(); tick();

      // kernel-mode fault ignored; branch masked by load-use, then taken alone
      EXIllop = 1; EXPC = 32'h80000100;
      @(negedge clk);
      chk("kern_ExcTake", 32'(ExcTake), 32'd0);
      tick(); idle();
      IDBranchTaken = 1; EXMemRead = 1; EXrt = 3; IDrs = 3;
      @(negedge clk);
      chk("br_lu_IFIDFlush", 32'(IFIDFlush), 32'd0);
      tick();
      EXMemRead = 0;
      @(negedge clk);
      chk("br_IFIDFlush", 32'(IFIDFlush), 32'd1);
      tick(); idle();

      // reset during a freeze clears the counter and lands in RUN
      MemBusy = 1;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      chk("rstfrz_StallCnt", 32'(StallCnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      MemBusy = 0; EXIllop = 1; EXPC = 32'h00000040;
      @(negedge clk);
      chk("rstfrz_ExcTake", 32'(ExcTake), 32'd1);
      tick(); idle(); tick();

      // saturation and clear priority
      MemBusy = 1;
      repeat (CNT_MAX + 5) tick();
      @(negedge clk);
      chk("sat_StallCnt", 32'(StallCnt), 32'(CNT_MAX));
      PerfClr = 1;
      tick(); idle();
      @(negedge clk);
      chk("clr_StallCnt", 32'(StallCnt), 32'd0);
      tick();

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
      IRQ = 1;
      tick(); IRQ = 0;
      @(negedge clk);
      chk("irq_ExcTake", 32'(ExcTake), 32'd1);
      chk("irq_ExcVector", ExcVector, 32'h80000000);
      tick();
      @(negedge clk);
      chk("irq_hold_ExcTake", 32'(ExcTake), 32'd0);
      tick(); tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline.
- Produces write-enable, flush and redirect controls for PC, IF/ID, ID/EX and EX/MEM.
- Resolves load-use hazards, ID-stage branch flushes, memory-busy freezes and EX-stage exceptions (illegal op, bad address).
- Drives the EX/MEM register's exception-capture inputs and keeps a saturating stall-cycle counter.

Parameters:
- ILLOP_VEC, 32'h80000004, exception vector for illegal opcode
- XADR_VEC, 32'h80000008, exception vector for bad address
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- IDrs  in  5  rs of instruction in ID
- IDrt  in  5  rt of instruction in ID
- IDUsesRt  in  1  ID instruction reads rt
- IDBranchTaken  in  1  branch/jump resolved taken in ID
- EXrt  in  5  destination rt of instruction in EX
- EXMemRead  in  1  EX instruction is a load
- EXPC  in  32  PC of EX instruction
- EXIllop  in  1  EX instruction is illegal
- EXXadr  in  1  EX instruction raised address fault
- MemBusy  in  1  data memory not ready this cycle
- PerfClr  in  1  synchronous clear of stall counter
- IRQ  in  1  external interrupt request (IRQ_EN only)
- PCWrite  out  1  PC update enable
- PCSelExc  out  1  PC loads ExcVector
- IFIDWrite  out  1  IF/ID enable
- IFIDFlush  out  1  IF/ID becomes bubble
- IDEXWrite  out  1  ID/EX enable
- IDEXFlush  out  1  ID/EX becomes bubble
- EXMEMWrite  out  1  EX/MEM enable
- ExcTake  out  1  to EX/MEM exception-capture input
- ExcVector  out  32  selected vector
- StallCnt  out  CNT_W  cycles with PCWrite=0

Behaviour:
- FSM states: RUN, FREEZE, EXC_HOLD. Reset state RUN.
- Outputs are combinational from state and inputs.
- Reset values: StallCnt=0. Control outputs in RUN with idle inputs: all Write=1, all Flush=0, ExcTake=0, PCSelExc=0, ExcVector=ILLOP_VEC.
- Precedence within a cycle: exception > MemBusy > load-use > branch.
- Exception condition: (EXIllop|EXXadr) and EXPC[31]==0; exceptions from kernel mode are ignored.
- Exception response: ExcTake=1, PCWrite=1, PCSelExc=1, IFIDFlush=1, IDEXFlush=1. ExcVector=ILLOP_VEC if EXIllop, else XADR_VEC; EXIllop wins if both.
- Exception timing: taken only in RUN and when MemBusy=0; next state EXC_HOLD. If MemBusy=1, the exception is deferred while EX holds.
- EXC_HOLD: lasts exactly 1 cycle and suppresses exception detection; other rules apply as in RUN. Returns to RUN.
- MemBusy=1 (any state, no exception): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, no flushes; state FREEZE.
- FREEZE: held while MemBusy=1; on MemBusy=0 returns to RUN. The deferred exception is then evaluated in the following RUN cycle.
- Load-use hazard: EXMemRead && EXrt!=0 && (EXrt==IDrs || (IDUsesRt && EXrt==IDrt)).
- Load-use response: PCWrite=0, IFIDWrite=0, IDEXFlush=1 for one cycle. The hazard clears because the load moves to MEM.
- Branch: IDBranchTaken with no higher-priority event → IFIDFlush=1. IDBranchTaken during a load-use stall is ignored that cycle; the branch re-resolves next cycle.
- StallCnt: increments each cycle PCWrite=0 and saturates at all-ones. PerfClr=1 forces 0 next edge and has priority over increment.
- Reset mid-freeze or mid-hold: immediately returns to RUN with counter cleared.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_IRQ_EN.
- Enabled: a pending flop sets on IRQ=1 and clears when the interrupt is taken.
- Enabled, take condition: in RUN with MemBusy=0, no EX exception and EXPC[31]==0.
- Enabled, take response: as an exception with ExcVector=32'h80000000 (priority below EXIllop/EXXadr), then EXC_HOLD.
- Disabled: the IRQ port is absent, there is no pending flop and 32'h80000000 is never produced.

Test Plan:
- Reset low for 3 cycles, release → all Write=1, Flush=0, StallCnt=0, state RUN.
- EXMemRead=1, EXrt=5, IDrs=5 for 1 cycle → PCWrite=0, IFIDWrite=0, IDEXFlush=1, StallCnt=1. Same with EXrt=0 → no stall.
- EXIllop=1, EXPC=32'h00400010 → ExcTake=1, ExcVector=32'h80000004, both flushes. Next cycle EXIllop held =1 → ExcTake=0 (EXC_HOLD). EXIllop=1 and EXXadr=1 together → vector 32'h80000004.
- EXXadr=1 with MemBusy=1 for 3 cycles → ExcTake=0, all Write=0, StallCnt +3. Cycle after MemBusy=0 → ExcTake=1, ExcVector=32'h80000008.
- EXIllop=1, EXPC=32'h80000100 → ExcTake=0. IDBranchTaken=1 with a load-use hazard → IFIDFlush=0; next cycle IDBranchTaken=1 alone → IFIDFlush=1.
- StallCnt preloaded near 16'hFFFF by a long MemBusy → holds 16'hFFFF. PerfClr=1 → 0. With IRQ_EN: IRQ pulse in RUN → ExcVector=32'h80000000, ExcTake=1.
